// File: rtl/siso_ctrl_pkg.sv
// rtl/siso_ctrl_pkg.sv - shared state encoding and default sizes for siso_ctrl
package siso_ctrl_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/siso_ctrl_if.sv
// rtl/siso_ctrl_if.sv - word handshake and serial stream signals of siso_ctrl
interface siso_ctrl_if
   import siso_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             busy;
   logic             done;

   modport master (
      output data_in, data_valid,
      input  data_ready, ser_out, ser_valid, busy, done
   );

   modport slave (
      input  data_in, data_valid,
      output data_ready, ser_out, ser_valid, busy, done
   );
endinterface

// File: rtl/siso_ctrl_siso.sv
// rtl/siso_ctrl_siso.sv - serial-in serial-out shift register, DEPTH stages
module siso_ctrl_siso #(
   parameter int DEPTH = 4
) (
   input  logic in,
   input  logic rst,
   input  logic clk,
   output logic out
);
   logic [DEPTH-1:0] stage_q, stage_d;

   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = in;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign out = stage_q[DEPTH-1];
endmodule

// File: rtl/siso_ctrl.sv
// rtl/siso_ctrl.sv - captures a parallel word and streams it MSB first through a shift chain
module siso_ctrl
   import siso_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   siso_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam int FW = $clog2(DEPTH) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
   logic [DEPTH-1:0] tag_q, tag_d;
   logic             chain_in;
   logic             tag_in;
   logic             bit_sel;
   logic             handshake;

   // Ready is gated by rst so it drops the instant reset is raised.
   assign bus.data_ready = (state_q == IDLE) && !rst;
   assign handshake      = bus.data_valid && bus.data_ready;

   always_comb begin
      bit_sel = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bit_cnt_q == CW'(WIDTH - 1 - i)) begin
            bit_sel = hold_q[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      bit_cnt_d   = bit_cnt_q;
      flush_cnt_d = flush_cnt_q;
      chain_in    = 1'b0;
      tag_in      = 1'b0;
      case (state_q)
         IDLE: begin
            if (handshake) begin
               hold_d    = bus.data_in;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            chain_in  = bit_sel;
            tag_in    = 1'b1;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(WIDTH - 1)) begin
               flush_cnt_d = '0;
               state_d     = FLUSH;
            end
         end
         FLUSH: begin
            // Zeros pushed here drain the last data bit out of the chain.
            if (flush_cnt_q == FW'(DEPTH - 1)) begin
               state_d = DONE;
            end else begin
               flush_cnt_d = flush_cnt_q + FW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      tag_d    = tag_q;
      tag_d[0] = tag_in;
      for (int i = 1; i < DEPTH; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         bit_cnt_q   <= '0;
         flush_cnt_q <= '0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         bit_cnt_q   <= bit_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         tag_q       <= tag_d;
      end
   end

   siso_ctrl_siso #(
      .DEPTH (DEPTH)
   ) u_chain (
      .in  (chain_in),
      .rst (rst),
      .clk (clk),
      .out (bus.ser_out)
   );

   assign bus.ser_valid = tag_q[DEPTH-1];
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_siso_ctrl.sv
// tb/tb_siso_ctrl.sv - directed self-checking bench for siso_ctrl (WIDTH=8, DEPTH=4)
module tb_siso_ctrl;
   import siso_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   siso_ctrl_if #(.WIDTH(8)) bus ();

   siso_ctrl #(
      .WIDTH (8),
      .DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".ser_out"},   {31'd0, bus.ser_out},   32'd0);
      check({tag, ".ser_valid"}, {31'd0, bus.ser_valid}, 32'd0);
      check({tag, ".busy"},      {31'd0, bus.busy},      32'd0);
      check({tag, ".done"},      {31'd0, bus.done},      32'd0);
   endtask

   // Called right after the handshake edge E0; walks E1..E13.
   task automatic stream_check(input logic [7:0] w, input bit scramble);
      logic exp_v, exp_o, exp_d, exp_r;
      check("e0.busy",  {31'd0, bus.busy},       32'd1);
      check("e0.ready", {31'd0, bus.data_ready}, 32'd0);
      for (int k = 1; k <= 13; k++) begin
         tick();
         exp_v = (k >= 4) && (k <= 11);
         exp_o = exp_v ? w[11-k] : 1'b0;
         exp_d = (k == 12);
         exp_r = (k == 13);
         check($sformatf("e%0d.ser_valid", k), {31'd0, bus.ser_valid},  {31'd0, exp_v});
         check($sformatf("e%0d.ser_out", k),   {31'd0, bus.ser_out},    {31'd0, exp_o});
         check($sformatf("e%0d.done", k),      {31'd0, bus.done},       {31'd0, exp_d});
         check($sformatf("e%0d.ready", k),     {31'd0, bus.data_ready}, {31'd0, exp_r});
         check($sformatf("e%0d.busy", k),      {31'd0, bus.busy},       {31'd0, !exp_r});
         if (scramble && k <= 11) begin
            bus.data_in    = 8'($urandom);
            bus.data_valid = k[0];
         end else if (scramble) begin
            bus.data_valid = 1'b0;
         end
      end
   endtask

   initial begin
      bus.data_in    = 8'h00;
      bus.data_valid = 1'b0;

      // Reset state, including data_ready low while rst is high
      #2;
      check_quiet("rst");
      check("rst.ready", {31'd0, bus.data_ready}, 32'd0);
      tick();
      tick();
      check_quiet("rst2");
      rst = 1'b0;
      #1;
      check("rel.ready", {31'd0, bus.data_ready}, 32'd1);
      check_quiet("rel");

      // Single word 8'hA5
      bus.data_in    = 8'hA5;
      bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0;
      stream_check(8'hA5, 1'b0);

      // data_valid held high across two back-to-back words
      bus.data_in    = 8'h3C;
      bus.data_valid = 1'b1;
      tick();
      bus.data_in    = 8'h81;
      stream_check(8'h3C, 1'b0);
      tick();
      bus.data_valid = 1'b0;
      stream_check(8'h81, 1'b0);

      // Reset mid-SHIFT after three bits have appeared on ser_out
      bus.data_in    = 8'hFF;
      bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
      end
      check("pre_rst.ser_valid", {31'd0, bus.ser_valid}, 32'd1);
      check("pre_rst.ser_out",   {31'd0, bus.ser_out},   32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_quiet("abort");
      check("abort.ready", {31'd0, bus.data_ready}, 32'd0);
      tick();
      check_quiet("abort2");
      rst = 1'b0;
      #1;
      check("abort_rel.ready", {31'd0, bus.data_ready}, 32'd1);
      for (int k = 0; k < 12; k++) begin
         tick();
         check($sformatf("no_done%0d", k), {31'd0, bus.done}, 32'd0);
      end

      // Next word after abort, with input noise while busy
      bus.data_in    = 8'h6D;
      bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0;
      stream_check(8'h6D, 1'b1);

      // Idle run
      bus.data_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         check($sformatf("idle%0d.ser_valid", k), {31'd0, bus.ser_valid}, 32'd0);
         check($sformatf("idle%0d.ser_out", k),   {31'd0, bus.ser_out},   32'd0);
         check($sformatf("idle%0d.done", k),      {31'd0, bus.done},      32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
